stim_scheduler: RTL and testbench

Round-robin scheduler that shares one `signal_gen` stimulus generator among `NUM_REQ` gate-test channels. It sits between the per-gate test harnesses and `signal_gen`. It grants one channel at a time and launches a stimulus sweep. It routes the generated `stm_value` to the granted channel, waits for the generator's `gnt`, and returns a per-channel completion pulse. A watchdog aborts sweeps that hang.

---
 rtl/stim_sched_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 35 +++
 rtl/stim_scheduler.sv | 162 ++++++++++++++++
 tb/tb_stim_scheduler.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/stim_sched_pkg.sv
// ---------------------------------------------------------------------------
// stim_sched_pkg
// Shared types and helpers for the stimulus scheduler.
//   state_t   : scheduler FSM state (IDLE=0, LAUNCH=1, WAIT=2, DONE=3)
//   cnt_width : bit width of a counter that must reach max(hold, timeout)-1
// ---------------------------------------------------------------------------
package stim_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // One counter serves both the LAUNCH hold and the WAIT watchdog,
    // so it is sized for the larger of the two terminal counts.
    function automatic int cnt_width(input int hold, input int timeout);
        int m;
        m = (hold > timeout) ? hold : timeout;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker: returns the first set request bit at or
// above the pointer, wrapping past N-1 back to 0.
//   i_req   [N-1:0]   : request vector
//   i_ptr   [IDW-1:0] : highest-priority position for this pick
//   o_valid           : at least one request is set
//   o_idx   [IDW-1:0] : index of the winning request (0 when none)
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   i_req,
    input  logic [IDW-1:0] i_ptr,
    output logic           o_valid,
    output logic [IDW-1:0] o_idx
);

    int unsigned w_pos;

    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_pos   = 0;
        for (int unsigned i = 0; i < N; i++) begin
            w_pos = (int'(i_ptr) + i) % N;
            if (!o_valid && i_req[IDW'(w_pos)]) begin
                o_valid = 1'b1;
                o_idx   = IDW'(w_pos);
            end
        end
    end

endmodule

// File: rtl/stim_scheduler.sv
// ---------------------------------------------------------------------------
// stim_scheduler
// Shares one signal_gen among NUM_REQ gate-test channels, one sweep at a time,
// in round-robin order, with a watchdog on the generator's completion.
//   clk           : clock, rising edge
//   rst           : asynchronous active-low reset
//   req_in        : per-channel level request, held until done_out
//   done_out      : one-cycle completion pulse to the serviced channel
//   timeout_err   : one-cycle pulse alongside done_out when the sweep aborted
//   busy          : scheduler not idle
//   grant_id      : channel currently being serviced
//   gen_req       : request to signal_gen, held REQ_HOLD cycles per launch
//   gen_gnt       : sweep-complete indication from signal_gen
//   gen_stm_value : stimulus from signal_gen
//   stm_out       : stimulus forwarded to channels (0 when not routing)
//   stm_valid     : one-hot owner of stm_out
// ---------------------------------------------------------------------------
module stim_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int INPUT_PORTS = 3,
    parameter int REQ_HOLD    = 10,
    parameter int TIMEOUT     = 1024,
    parameter int IDW         = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_in,
    output logic [NUM_REQ-1:0]     done_out,
    output logic                   timeout_err,
    output logic                   busy,
    output logic [IDW-1:0]         grant_id,
    output logic                   gen_req,
    input  logic                   gen_gnt,
    input  logic [INPUT_PORTS-1:0] gen_stm_value,
    output logic [INPUT_PORTS-1:0] stm_out,
    output logic [NUM_REQ-1:0]     stm_valid
);

    import stim_sched_pkg::*;

    localparam int          CW        = cnt_width(REQ_HOLD, TIMEOUT);
    localparam logic [CW-1:0] HOLD_LAST = CW'(REQ_HOLD - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);

    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic [IDW-1:0]       r_rr_ptr;
    logic [IDW-1:0]       r_grant_id;
    logic                 r_gen_req;
    logic                 r_gnt_seen;
    logic                 r_withdrawn;
    logic                 r_busy;
    logic                 r_timeout_err;
    logic [NUM_REQ-1:0]   r_done_out;
    logic [NUM_REQ-1:0]   r_stm_valid;

    logic                 w_arb_valid;
    logic [IDW-1:0]       w_arb_idx;
    logic [NUM_REQ-1:0]   w_arb_onehot;
    logic [NUM_REQ-1:0]   w_grant_onehot;
    logic                 w_req_held;
    logic                 w_keep;
    logic                 w_gnt;
    logic                 w_route;
    logic [IDW-1:0]       w_next_ptr;

    rr_arbiter #(
        .N   (NUM_REQ),
        .IDW (IDW)
    ) u_arb (
        .i_req   (req_in),
        .i_ptr   (r_rr_ptr),
        .o_valid (w_arb_valid),
        .o_idx   (w_arb_idx)
    );

    always_comb begin
        w_arb_onehot   = NUM_REQ'(1) << w_arb_idx;
        w_grant_onehot = NUM_REQ'(1) << r_grant_id;
        w_req_held     = req_in[r_grant_id];
        // Completion is reported only if the channel never let go of its
        // request during the sweep, including on the final WAIT edge.
        w_keep         = ~r_withdrawn & w_req_held;
        // A grant seen during LAUNCH is remembered and honoured in WAIT.
        w_gnt          = gen_gnt | r_gnt_seen;
        w_route        = (r_state == ST_LAUNCH) || (r_state == ST_WAIT);
        w_next_ptr     = (r_grant_id == IDW'(NUM_REQ - 1)) ? '0 : r_grant_id + IDW'(1);
        stm_out        = w_route ? gen_stm_value : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_rr_ptr      <= '0;
            r_grant_id    <= '0;
            r_gen_req     <= 1'b0;
            r_gnt_seen    <= 1'b0;
            r_withdrawn   <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_done_out    <= '0;
            r_stm_valid   <= '0;
        end else begin
            r_done_out    <= '0;
            r_timeout_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_arb_valid) begin
                        r_state     <= ST_LAUNCH;
                        r_grant_id  <= w_arb_idx;
                        r_gen_req   <= 1'b1;
                        r_busy      <= 1'b1;
                        r_cnt       <= '0;
                        r_gnt_seen  <= 1'b0;
                        r_withdrawn <= 1'b0;
                        r_stm_valid <= w_arb_onehot;
                    end
                end
                ST_LAUNCH: begin
                    r_gnt_seen <= r_gnt_seen | gen_gnt;
                    if (!w_req_held) r_withdrawn <= 1'b1;
                    if (r_cnt == HOLD_LAST) begin
                        r_state   <= ST_WAIT;
                        r_gen_req <= 1'b0;
                        r_cnt     <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_WAIT: begin
                    if (!w_req_held) r_withdrawn <= 1'b1;
                    // A grant on the terminal count wins over the abort.
                    if (w_gnt || (r_cnt == TO_LAST)) begin
                        r_state     <= ST_DONE;
                        r_stm_valid <= '0;
                        if (w_keep) begin
                            r_done_out    <= w_grant_onehot;
                            r_timeout_err <= ~w_gnt;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_DONE: begin
                    r_state  <= ST_IDLE;
                    r_busy   <= 1'b0;
                    r_rr_ptr <= w_next_ptr;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign done_out    = r_done_out;
    assign timeout_err = r_timeout_err;
    assign busy        = r_busy;
    assign grant_id    = r_grant_id;
    assign gen_req     = r_gen_req;
    assign stm_valid   = r_stm_valid;

endmodule

// File: tb/tb_stim_scheduler.sv
module tb_stim_scheduler;

    localparam int NUM_REQ     = 4;
    localparam int INPUT_PORTS = 3;
    localparam int REQ_HOLD    = 10;
    localparam int TIMEOUT     = 16;
    localparam int IDW         = 2;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic [NUM_REQ-1:0]     req_in = '0;
    logic [NUM_REQ-1:0]     done_out;
    logic                   timeout_err;
    logic                   busy;
    logic [IDW-1:0]         grant_id;
    logic                   gen_req;
    logic                   gen_gnt = 1'b0;
    logic [INPUT_PORTS-1:0] gen_stm_value = '0;
    logic [INPUT_PORTS-1:0] stm_out;
    logic [NUM_REQ-1:0]     stm_valid;

    int vectors     = 0;
    int miscompares = 0;
    int m_ptr       = 0;   // reference round-robin pointer
    bit step_mode   = 1'b0;

    stim_scheduler #(
        .NUM_REQ     (NUM_REQ),
        .INPUT_PORTS (INPUT_PORTS),
        .REQ_HOLD    (REQ_HOLD),
        .TIMEOUT     (TIMEOUT),
        .IDW         (IDW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_in        (req_in),
        .done_out      (done_out),
        .timeout_err   (timeout_err),
        .busy          (busy),
        .grant_id      (grant_id),
        .gen_req       (gen_req),
        .gen_gnt       (gen_gnt),
        .gen_stm_value (gen_stm_value),
        .stm_out       (stm_out),
        .stm_valid     (stm_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input bit exp_req, input bit exp_busy,
                                 input logic [3:0] exp_valid, input logic [3:0] exp_done,
                                 input bit exp_to, input bit routed);
        check({tag, ".gen_req"},     32'(gen_req),     32'(exp_req));
        check({tag, ".busy"},        32'(busy),        32'(exp_busy));
        check({tag, ".stm_valid"},   32'(stm_valid),   32'(exp_valid));
        check({tag, ".done_out"},    32'(done_out),    32'(exp_done));
        check({tag, ".timeout_err"}, 32'(timeout_err), 32'(exp_to));
        check({tag, ".stm_out"},     32'(stm_out),     routed ? 32'(gen_stm_value) : 32'd0);
    endtask

    // Reference arbitration: first requester at or after the pointer.
    function automatic int pick(input logic [3:0] req, input int ptr);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req[(ptr + i) % NUM_REQ]) return (ptr + i) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic next_stim();
        if (step_mode) gen_stm_value = gen_stm_value + 3'd1;
        else           gen_stm_value = 3'($urandom_range(0, 7));
    endtask

    // One sweep from an IDLE negedge through the DONE negedge.
    // mode 0: gnt on WAIT cycle d; mode 1: gnt on LAUNCH cycle d; mode 2: never.
    // wk: WAIT cycle on which the granted channel drops its request (0 = never).
    // rst_at: WAIT cycle on which reset is asserted (0 = never).
    task automatic sweep(input logic [3:0] add_req, input int mode, input int d,
                         input int wk, input bit keep, input bit step_stm, input int rst_at);
        int win, e;
        logic [3:0] oh;
        bit wd;
        wd = 1'b0;
        @(negedge clk);
        check_outputs("idle", 1'b0, 1'b0, 4'b0, 4'b0, 1'b0, 1'b0);
        req_in = req_in | add_req;
        win = pick(req_in, m_ptr);
        oh  = 4'b0001 << win;
        e   = (mode == 1) ? 1 : (mode == 0) ? d : TIMEOUT;
        step_mode = 1'b0;
        for (int i = 0; i < REQ_HOLD; i++) begin
            @(negedge clk);
            gen_gnt = 1'b0;
            check_outputs("launch", 1'b1, 1'b1, oh, 4'b0, 1'b0, 1'b1);
            check("launch.grant_id", 32'(grant_id), 32'(win));
            next_stim();
            if (mode == 1 && i == d) gen_gnt = 1'b1;
        end
        if (step_stm) begin
            gen_stm_value = '0;
            step_mode = 1'b1;
        end
        for (int k = 1; k <= e; k++) begin
            @(negedge clk);
            gen_gnt = 1'b0;
            check_outputs("wait", 1'b0, 1'b1, oh, 4'b0, 1'b0, 1'b1);
            check("wait.grant_id", 32'(grant_id), 32'(win));
            if (k == rst_at) begin
                rst = 1'b0;
                #1;
                check_outputs("reset", 1'b0, 1'b0, 4'b0, 4'b0, 1'b0, 1'b0);
                check("reset.grant_id", 32'(grant_id), 32'd0);
                m_ptr = 0;
                step_mode = 1'b0;
                return;
            end
            next_stim();
            if (mode == 0 && k == d) gen_gnt = 1'b1;
            if (k == wk) begin
                req_in[win] = 1'b0;
                wd = 1'b1;
            end
        end
        @(negedge clk);
        gen_gnt = 1'b0;
        step_mode = 1'b0;
        check_outputs("done", 1'b0, 1'b1, 4'b0, wd ? 4'b0 : oh, (mode == 2) && !wd, 1'b0);
        check("done.grant_id", 32'(grant_id), 32'(win));
        m_ptr = (win + 1) % NUM_REQ;
        if (!keep) req_in[win] = 1'b0;
    endtask

    initial begin
        int mode, d, e, wk;
        logic [3:0] add;

        // Reset values
        #1;
        check_outputs("rst", 1'b0, 1'b0, 4'b0, 4'b0, 1'b0, 1'b0);
        check("rst.grant_id", 32'(grant_id), 32'd0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;

        // No requests: stays idle
        repeat (3) begin
            @(negedge clk);
            check_outputs("idle0", 1'b0, 1'b0, 4'b0, 4'b0, 1'b0, 1'b0);
        end

        // Fairness: all channels requesting continuously -> 0,1,2,3,0
        for (int s = 0; s < 5; s++) begin
            sweep(4'b1111, 0, int'($urandom_range(1, 5)), 0, 1'b1, 1'b0, 0);
            check("fair.order", 32'(grant_id), 32'(s % NUM_REQ));
        end
        req_in = '0;

        // Single request on channel 1, gnt 8 cycles after gen_req falls
        sweep(4'b0010, 0, 8, 0, 1'b0, 1'b0, 0);
        // Channel 2 withdraws mid-WAIT; channel 3 keeps requesting
        sweep(4'b1100, 0, 6, 3, 1'b0, 1'b0, 0);
        // Channel 3 next, with the generator stepping 000..111 during WAIT
        sweep(4'b0000, 0, 9, 0, 1'b0, 1'b1, 0);
        // Generator never answers -> timeout
        sweep(4'b0100, 2, 0, 0, 1'b0, 1'b0, 0);
        // Early gnt during LAUNCH
        sweep(4'b0001, 1, 4, 0, 1'b0, 1'b0, 0);
        // Early gnt on the last LAUNCH cycle
        sweep(4'b0010, 1, REQ_HOLD - 1, 0, 1'b0, 1'b0, 0);
        // gnt on the last WAIT cycle before the watchdog would fire
        sweep(4'b0100, 0, TIMEOUT - 1, 0, 1'b0, 1'b0, 0);
        // Reset during WAIT, then a pending request on channel 0
        sweep(4'b1000, 0, 10, 0, 1'b0, 1'b0, 5);
        req_in  = 4'b0001;
        gen_gnt = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        sweep(4'b0000, 0, 3, 0, 1'b0, 1'b0, 0);

        // Randomized sweeps against the reference model
        for (int s = 0; s < 40; s++) begin
            add = 4'($urandom_range(0, 15));
            if ((req_in | add) == 4'b0) add = 4'b0001 << $urandom_range(0, 3);
            mode = int'($urandom_range(0, 2));
            if (mode == 0)      d = int'($urandom_range(1, TIMEOUT - 1));
            else if (mode == 1) d = int'($urandom_range(0, REQ_HOLD - 1));
            else                d = 0;
            e  = (mode == 1) ? 1 : d;
            wk = (mode != 2 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, e)) : 0;
            sweep(add, mode, d, wk, 1'($urandom_range(0, 1)), 1'b0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
